// File: rtl/ctrl_io_dr_pkg.sv
// Shared dual-rail definitions for the IO pad bridge and other dual-rail tiles.
package ctrl_io_dr_pkg;

    // Dual-rail codewords as {true, false} rail pairs
    localparam logic [1:0] DR_SPACER  = 2'b00;
    localparam logic [1:0] DR_ZERO    = 2'b01;
    localparam logic [1:0] DR_ONE     = 2'b10;
    localparam logic [1:0] DR_INVALID = 2'b11;

    // Precharge places the spacer on the rails, evaluate carries data
    typedef enum logic {
        PRECH = 1'b0,
        EVAL  = 1'b1
    } phase_t;

    // A rail pair carries data only when exactly one rail is high
    function automatic logic dr_valid(input logic t, input logic f);
        return t ^ f;
    endfunction

endpackage

// File: rtl/ctrl_io_dr_phase_gen.sv
// Precharge/evaluate phase generator with first/last evaluate strobes.
module ctrl_io_dr_phase_gen
    import ctrl_io_dr_pkg::*;
#(
    parameter int PRECH_CYCLES = 1,
    parameter int EVAL_CYCLES  = 2
) (
    input  logic   i_clk,
    input  logic   i_rst,
    output phase_t o_phase,
    output logic   o_prech2,
    output logic   o_enterEval,
    output logic   o_firstEval,
    output logic   o_lastEval
);

    localparam int MAX_CYCLES = (PRECH_CYCLES > EVAL_CYCLES) ? PRECH_CYCLES : EVAL_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] PRECH_LOAD = CNT_W'(PRECH_CYCLES - 1);
    localparam logic [CNT_W-1:0] EVAL_LOAD  = CNT_W'(EVAL_CYCLES - 1);

    phase_t           r_phase;
    logic [CNT_W-1:0] r_cnt;
    logic             r_prech2;

    // Phase FSM: count down the current phase, then swap phase and reload the counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_phase  <= PRECH;
            r_cnt    <= PRECH_LOAD;
            r_prech2 <= 1'b0;
        end else if (r_cnt == '0) begin
            if (r_phase == PRECH) begin
                r_phase  <= EVAL;
                r_cnt    <= EVAL_LOAD;
                r_prech2 <= 1'b1;
            end else begin
                r_phase  <= PRECH;
                r_cnt    <= PRECH_LOAD;
                r_prech2 <= 1'b0;
            end
        end else begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_phase     = r_phase;
    assign o_prech2    = r_prech2;
    assign o_enterEval = (r_phase == PRECH) && (r_cnt == '0);
    assign o_firstEval = (r_phase == EVAL) && (r_cnt == EVAL_LOAD);
    assign o_lastEval  = (r_phase == EVAL) && (r_cnt == '0);

endmodule

// File: rtl/ctrl_io_dr_pad_bridge.sv
// Pad-side bridge for one dual-rail IO column: registers pad traffic in both
// directions, generates the precharge phase and aggregates dual-rail faults.
module ctrl_io_dr_pad_bridge
    import ctrl_io_dr_pkg::*;
#(
    parameter int NUM_IO       = 4,
    parameter int PRECH_CYCLES = 1,
    parameter int EVAL_CYCLES  = 2,
    parameter int FCNT_W       = 8
) (
    input  logic              UserCLK,
    input  logic              rst,
    input  logic [NUM_IO-1:0] I_top_t,
    input  logic [NUM_IO-1:0] I_top_f,
    input  logic [NUM_IO-1:0] T_top,
    input  logic [NUM_IO-1:0] F_ctrl,
    input  logic [NUM_IO-1:0] pad_in_t,
    input  logic [NUM_IO-1:0] pad_in_f,
    input  logic              fault_clear,
    output logic [NUM_IO-1:0] O_top_t,
    output logic [NUM_IO-1:0] O_top_f,
    output logic              prech2,
    output logic [NUM_IO-1:0] pad_out_t,
    output logic [NUM_IO-1:0] pad_out_f,
    output logic [NUM_IO-1:0] pad_oe,
    output logic              DR_fault,
    output logic [FCNT_W-1:0] fault_count
);

    phase_t            w_phase;
    logic              w_prech2;
    logic              w_enterEval;
    logic              w_firstEval;
    logic              w_lastEval;
    logic              w_checkWindow;
    logic              w_inBad;
    logic              w_outBad;
    logic              w_event;

    logic [NUM_IO-1:0] r_oTopT;
    logic [NUM_IO-1:0] r_oTopF;
    logic [NUM_IO-1:0] r_padOutT;
    logic [NUM_IO-1:0] r_padOutF;
    logic [NUM_IO-1:0] r_padOe;
    logic              r_drFault;
    logic [FCNT_W-1:0] r_faultCount;

    ctrl_io_dr_phase_gen #(
        .PRECH_CYCLES (PRECH_CYCLES),
        .EVAL_CYCLES  (EVAL_CYCLES)
    ) u_phaseGen (
        .i_clk       (UserCLK),
        .i_rst       (rst),
        .o_phase     (w_phase),
        .o_prech2    (w_prech2),
        .o_enterEval (w_enterEval),
        .o_firstEval (w_firstEval),
        .o_lastEval  (w_lastEval)
    );

    // Inbound: capture the pad pair as evaluate begins so tiles see it for the whole
    // evaluate phase, then drive the spacer as precharge begins
    always_ff @(posedge UserCLK or posedge rst) begin
        if (rst) begin
            r_oTopT <= '0;
            r_oTopF <= '0;
        end else if (w_enterEval) begin
            r_oTopT <= pad_in_t;
            r_oTopF <= pad_in_f;
        end else if (w_lastEval) begin
            r_oTopT <= '0;
            r_oTopF <= '0;
        end
    end

    // Outbound: on the last evaluate cycle, load valid driven pairs, keep the old
    // value on an invalid pair, and release the pad when the tile tristates it
    always_ff @(posedge UserCLK or posedge rst) begin
        if (rst) begin
            r_padOutT <= '0;
            r_padOutF <= '0;
            r_padOe   <= '0;
        end else if (w_lastEval) begin
            for (int i = 0; i < NUM_IO; i++) begin
                if (T_top[i]) begin
                    r_padOe[i] <= 1'b0;
                end else if (dr_valid(I_top_t[i], I_top_f[i])) begin
                    r_padOutT[i] <= I_top_t[i];
                    r_padOutF[i] <= I_top_f[i];
                    r_padOe[i]   <= 1'b1;
                end
            end
        end
    end

    // Fault sources are only trusted after the first evaluate cycle, once rails settle;
    // all sources in one cycle collapse into a single event
    always_comb begin
        w_inBad  = 1'b0;
        w_outBad = 1'b0;
        for (int i = 0; i < NUM_IO; i++) begin
            if (!dr_valid(r_oTopT[i], r_oTopF[i])) begin
                w_inBad = 1'b1;
            end
            if (!T_top[i] && !dr_valid(I_top_t[i], I_top_f[i])) begin
                w_outBad = 1'b1;
            end
        end
        w_checkWindow = (w_phase == EVAL) && !w_firstEval;
        w_event       = w_checkWindow && ((|F_ctrl) || w_inBad || (w_lastEval && w_outBad));
    end

    // Sticky fault flag and saturating event counter; a clear beats a same-cycle event
    always_ff @(posedge UserCLK or posedge rst) begin
        if (rst) begin
            r_drFault    <= 1'b0;
            r_faultCount <= '0;
        end else if (fault_clear) begin
            r_drFault    <= 1'b0;
            r_faultCount <= '0;
        end else if (w_event) begin
            r_drFault <= 1'b1;
            if (r_faultCount != '1) begin
                r_faultCount <= r_faultCount + FCNT_W'(1);
            end
        end
    end

    assign O_top_t     = r_oTopT;
    assign O_top_f     = r_oTopF;
    assign prech2      = w_prech2;
    assign pad_out_t   = r_padOutT;
    assign pad_out_f   = r_padOutF;
    assign pad_oe      = r_padOe;
    assign DR_fault    = r_drFault;
    assign fault_count = r_faultCount;

endmodule

// File: doc/ctrl_io_dr_pad_bridge.md
Name: ctrl_io_dr_pad_bridge

Overview:
- Pad-side counterpart of the dual-rail fabric IO BEL. Sits at fabric top level, one instance per IO column.
- Consumes `I_top_*_t/f`, `T_top` and `F_ctrl` exported by the IO tiles and drives registered dual-rail pad outputs.
- Returns external pad data as `O_top_*_t/f` and generates the `prech2` precharge/evaluate phase.
- Aggregates dual-rail faults into a sticky `DR_fault` returned to every tile.

Parameters:
- NUM_IO, 4, number of dual-rail IO channels served.
- PRECH_CYCLES, 1, clock cycles per precharge phase (≥1).
- EVAL_CYCLES, 2, clock cycles per evaluate phase (≥2).
- FCNT_W, 8, width of saturating fault counter.

Ports:
- UserCLK  in  1  fabric user clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- I_top_t  in  NUM_IO  true rail from fabric toward pad.
- I_top_f  in  NUM_IO  false rail from fabric toward pad.
- T_top  in  NUM_IO  inverted tristate from tile; 0 = fabric drives pad.
- F_ctrl  in  NUM_IO  per-tile invalid-codeword flag.
- pad_in_t  in  NUM_IO  true rail arriving from external pad.
- pad_in_f  in  NUM_IO  false rail arriving from external pad.
- fault_clear  in  1  synchronous clear of sticky fault and counter.
- O_top_t  out  NUM_IO  true rail toward tile.
- O_top_f  out  NUM_IO  false rail toward tile.
- prech2  out  1  phase signal; 0 = precharge, 1 = evaluate.
- pad_out_t  out  NUM_IO  registered true rail to pad.
- pad_out_f  out  NUM_IO  registered false rail to pad.
- pad_oe  out  NUM_IO  pad output enable.
- DR_fault  out  1  sticky fault, broadcast to tiles.
- fault_count  out  FCNT_W  saturating count of fault events.

Behaviour:
- Reset values:
  - FSM = PRECH, `prech2` = 0.
  - `O_top_t/f`, `pad_out_t/f` and `pad_oe` all 0.
  - `DR_fault` = 0, `fault_count` = 0.
- Phase FSM: PRECH → EVAL after PRECH_CYCLES; EVAL → PRECH after EVAL_CYCLES. Period is PRECH_CYCLES + EVAL_CYCLES.
  - Phase counter width = clog2(max(PRECH_CYCLES, EVAL_CYCLES)).
  - Counter reloads on each transition.
- `prech2` is registered: 1 exactly during EVAL cycles, 0 during PRECH.
- Inbound path:
  - On the first EVAL cycle, register `pad_in_t/f` into `O_top_t/f`. Values are held for the rest of EVAL.
  - On entry to PRECH, force `O_top` to 00 (spacer). Latency from pad sample to tile-visible data is 1 cycle.
  - Pad pair 11 is captured as-is and counted as a fault. Pair 00 in EVAL is captured as-is and counted as a fault.
- Outbound path, sampled on the last EVAL cycle per channel i:
  - T_top[i] = 0 and (I_top_t ^ I_top_f) = 1 → load `pad_out` ← I_top, `pad_oe[i]` ← 1.
  - T_top[i] = 0 and invalid pair (00/11) → hold previous `pad_out`; `pad_oe` unchanged; fault event.
  - T_top[i] = 1 → `pad_oe[i]` ← 0; `pad_out` holds.
  - `pad_out` is never changed during PRECH.
- Fault detection: only during EVAL cycles 2..EVAL_CYCLES. The first EVAL cycle is skipped to allow rail settling.
  - An event is raised when any F_ctrl bit is 1, or any inbound or outbound invalid pair is seen.
  - Multiple simultaneous sources in one cycle count as one event.
  - F_ctrl is ignored in PRECH, where the spacer 00 is legitimate.
- DR_fault: set the cycle after the first event. It is sticky until `fault_clear` or `rst`.
- fault_count: +1 per event cycle, saturating at 2^FCNT_W − 1.
- fault_clear together with an event in the same cycle: clear wins, so `DR_fault` = 0 and `fault_count` = 0. The event is lost.
- rst asserted mid-EVAL: all outputs return to reset values immediately (async). The FSM restarts in PRECH for a full PRECH_CYCLES after deassertion.

Decomposition:
- Shared package `ctrl_io_dr_pkg`:
  - Dual-rail codeword constants DR_SPACER = 2'b00, DR_ZERO = 2'b01, DR_ONE = 2'b10, DR_INVALID = 2'b11.
  - Phase enum {PRECH, EVAL}.
  - Function `dr_valid(t, f)`.
- One sub-module `ctrl_io_dr_phase_gen`: phase FSM, phase counter, `prech2`, and first/last-EVAL strobes. Reused by other dual-rail tiles.

Test Plan:
- Reset, then run 6 cycles with defaults: `prech2` sequence is 0,1,1,0,1,1. All `O_top` = 0 during PRECH cycles.
- pad_in ch0 = 10 held: `O_top_t[0]`/`O_top_f[0]` = 1/0 on both EVAL cycles and 0/0 on PRECH. `DR_fault` stays 0.
- T_top[1] = 0, I_top ch1 = 01 at last EVAL: `pad_out` ch1 = 01 and `pad_oe[1]` = 1 from the next cycle. Set T_top[1] = 1: `pad_oe[1]` = 0 after the next last-EVAL cycle.
- F_ctrl[2] = 1 during the second EVAL cycle: `DR_fault` = 1 and `fault_count` = 1 next cycle. F_ctrl[2] = 1 only during PRECH gives no change.
- I_top ch3 = 11 with T_top = 0 and F_ctrl[3] = 1 in the same cycle: `pad_out` ch3 holds its prior value, and `fault_count` increments by exactly 1.
- FCNT_W = 2 with 5 fault events: `fault_count` saturates at 3. fault_clear coincident with an event gives `DR_fault` = 0 and count 0. Async rst mid-EVAL makes `prech2` = 0 immediately.
